// File: rtl/cam_bram_alloc.sv
// cam_bram_alloc: slice-RAM CAM with per-entry key shadow, lowest-free allocation and a 2-cycle search pipeline
module cam_bram_alloc #(
  parameter int DATA_WIDTH  = 48,
  parameter int ADDR_WIDTH  = 5,
  parameter int SLICE_WIDTH = 9,
  parameter bit AUTO_ALLOC  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_WIDTH-1:0]    write_addr,
  input  logic [DATA_WIDTH-1:0]    write_data,
  input  logic                     write_delete,
  input  logic                     write_enable,
  output logic                     write_busy,
  output logic                     write_done,
  output logic                     write_error,
  output logic [ADDR_WIDTH-1:0]    write_result_addr,
  input  logic [DATA_WIDTH-1:0]    compare_data,
  input  logic                     compare_valid,
  output logic                     match_valid,
  output logic [2**ADDR_WIDTH-1:0] match_many,
  output logic [2**ADDR_WIDTH-1:0] match_single,
  output logic [ADDR_WIDTH-1:0]    match_addr,
  output logic                     match,
  output logic [ADDR_WIDTH:0]      entry_count,
  output logic                     full
);
  localparam int RAM_DEPTH   = 2**ADDR_WIDTH;
  localparam int SLICE_COUNT = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
  typedef enum logic [2:0] {INIT, IDLE, DEL_RD, DEL_RD2, DEL_WR, INS_RD, INS_WR, DONE} state_t;
  state_t                               r_state, w_next;
  logic [SLICE_WIDTH-1:0]               r_init_row;
  logic [RAM_DEPTH-1:0]                 r_valid, r_vmask, w_bit, w_hit;
  logic [ADDR_WIDTH-1:0]                r_tgt, w_free;
  logic [DATA_WIDTH-1:0]                r_key, r_old_key, r_cmp_key;
  logic [DATA_WIDTH-1:0]                r_shadow [RAM_DEPTH];
  logic                                 r_del, r_err, r_p1, r_p2;
  logic [ADDR_WIDTH:0]                  r_count, w_pop;
  logic [SLICE_COUNT-1:0][RAM_DEPTH-1:0] w_rows;
  assign w_bit             = RAM_DEPTH'(1) << r_tgt;
  assign write_busy        = r_state != IDLE;
  assign write_done        = r_state == DONE;
  assign write_error       = write_done & r_err;
  assign write_result_addr = r_tgt;
  assign entry_count       = r_count;
  assign full              = r_count == (ADDR_WIDTH+1)'(RAM_DEPTH);
  assign match_valid       = r_p2;
  assign match_many        = r_p2 ? (w_hit & r_vmask) : '0;
  assign match_single      = match_many & (-match_many);
  assign match             = |match_many;
  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:    w_next = &r_init_row ? IDLE : INIT;
      IDLE:    w_next = !write_enable ? IDLE : (AUTO_ALLOC && !write_delete && full) ? DONE : DEL_RD;
      DEL_RD:  w_next = DEL_RD2;
      DEL_RD2: w_next = DEL_WR;
      DEL_WR:  w_next = r_del ? DONE : INS_RD;
      INS_RD:  w_next = INS_WR;
      INS_WR:  w_next = DONE;
      DONE:    w_next = IDLE;
    endcase
  end
  always_comb begin
    w_pop      = '0;
    w_free     = '0;
    match_addr = '0;
    w_hit      = '1;
    for (int i = RAM_DEPTH - 1; i >= 0; i--) begin
      w_pop = w_pop + (ADDR_WIDTH+1)'(r_valid[i]);
      if (!r_valid[i]) w_free = ADDR_WIDTH'(i);
      if (match_many[i]) match_addr = ADDR_WIDTH'(i);
    end
    for (int i = 0; i < SLICE_COUNT; i++) w_hit = w_hit & w_rows[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT;
      r_init_row <= '0;
      r_valid    <= '0;
      r_vmask    <= '0;
      r_tgt      <= '0;
      r_key      <= '0;
      r_del      <= 1'b0;
      r_err      <= 1'b0;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      r_count <= w_pop;
      r_p1    <= compare_valid;
      r_p2    <= r_p1;
      r_vmask <= r_valid;
      if (r_state == INIT) r_init_row <= r_init_row + SLICE_WIDTH'(1);
      if (r_state == IDLE && write_enable) begin
        r_key <= write_data;
        r_del <= write_delete;
        r_tgt <= (AUTO_ALLOC && !write_delete) ? w_free : write_addr;
        r_err <= write_delete ? !r_valid[write_addr] : (AUTO_ALLOC && full);
      end
      if (r_state == DEL_WR) r_valid[r_tgt] <= 1'b0;
      if (r_state == INS_WR) r_valid[r_tgt] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    r_cmp_key <= compare_data;
    if (r_state == INS_WR) r_shadow[r_tgt] <= r_key;
    if (r_state == DEL_RD) r_old_key <= r_shadow[r_tgt];
  end
  // One RAM per key slice; every row update of a write lands on a single edge, so searches never see a half-written key
  for (genvar s = 0; s < SLICE_COUNT; s++) begin : g_slice
    localparam int W = (s == SLICE_COUNT - 1) ? DATA_WIDTH - s * SLICE_WIDTH : SLICE_WIDTH;
    logic [RAM_DEPTH-1:0] r_mem [2**W];
    logic [RAM_DEPTH-1:0] r_rd, r_wr, w_wdata;
    logic [W-1:0]         w_row;
    logic                 w_we;
    always_comb begin
      w_row   = (r_state == INIT) ? r_init_row[W-1:0] :
                (r_state == DEL_RD2 || r_state == DEL_WR) ? r_old_key[s*SLICE_WIDTH +: W] : r_key[s*SLICE_WIDTH +: W];
      w_we    = r_state == INIT || r_state == INS_WR || (r_state == DEL_WR && r_valid[r_tgt]);
      w_wdata = (r_state == INIT) ? '0 : (r_state == INS_WR) ? (r_wr | w_bit) : (r_wr & ~w_bit);
    end
    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_row] <= w_wdata;
      r_rd <= r_mem[r_cmp_key[s*SLICE_WIDTH +: W]];
      if (r_state == DEL_RD2 || r_state == INS_RD) r_wr <= r_mem[w_row];
    end
    assign w_rows[s] = r_rd;
  end
endmodule
